// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with a start/busy/done handshake.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module muldiv_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Start,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     Busy,
    output logic                     Done,
    output logic [DATA_WIDTH-1:0]    Result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    hi_q, lo_q, b_q;
    logic [CW-1:0]   cnt_q;
    logic            div_q, negq_q, negr_q;
    logic [1:0]      sel_q;

    logic            accept, last_iter, fast;
    logic            op_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, ovf;
    logic [W-1:0]    a_mag, b_mag, fast_res;
    logic            w_div;
    logic [W-1:0]    w_hi, w_lo, w_b;
    logic [W:0]      msum, dshift, ddiff;
    logic [W-1:0]    s_hi, s_lo;

    function automatic logic [W-1:0] fixup(input logic is_div, input logic [1:0] sel,
                                           input logic negq, input logic negr,
                                           input logic [W-1:0] hi, input logic [W-1:0] lo);
        logic [2*W-1:0] p;
        logic [W-1:0]   q, r;
        p = negq ? -{hi, lo} : {hi, lo};
        q = negq ? -lo : lo;
        r = negr ? -hi : hi;
        if (is_div) fixup = sel[1] ? r : q;
        else        fixup = (sel == 2'b00) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    assign accept    = Start && (state == IDLE);
    assign last_iter = (cnt_q == CW'(W-2));
    assign Busy      = (state != IDLE);
    assign Done      = (state == DONE);

    always_comb begin
        op_div   = Operation[2];
        a_sgn    = op_div ? ~Operation[0] : (Operation[1] ^ Operation[0]);
        b_sgn    = op_div ? ~Operation[0] : (Operation[1:0] == 2'b01);
        a_neg    = a_sgn & SrcA[W-1];
        b_neg    = b_sgn & SrcB[W-1];
        a_mag    = a_neg ? -SrcA : SrcA;
        b_mag    = b_neg ? -SrcB : SrcB;
        div_zero = op_div && (SrcB == '0);
        ovf      = op_div && !Operation[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
        fast_res = '0;
        if (div_zero)  fast_res = Operation[1] ? SrcA : '1;
        else if (ovf)  fast_res = Operation[1] ? '0 : SrcA;
`ifdef MULDIV_FAST_MUL_EN
        else if (!op_div) begin
            fast_res = fixup(1'b0, Operation[1:0], a_neg ^ b_neg, 1'b0,
                             W'(({{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag}) >> W),
                             W'({{W{1'b0}}, a_mag} * {{W{1'b0}}, b_mag}));
        end
        fast     = div_zero | ovf | ~op_div;
`else
        fast     = div_zero | ovf;
`endif
    end

    // The accept edge performs the first iteration on fresh magnitudes, so RUN
    // needs only W-1 cycles and Done lands W cycles after accept.
    always_comb begin
        if (state == IDLE) begin
            w_div = op_div;
            w_hi  = '0;
            w_lo  = op_div ? a_mag : b_mag;
            w_b   = op_div ? b_mag : a_mag;
        end else begin
            w_div = div_q;
            w_hi  = hi_q;
            w_lo  = lo_q;
            w_b   = b_q;
        end
        msum   = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : '0);
        dshift = {w_hi, w_lo[W-1]};
        ddiff  = dshift - {1'b0, w_b};
        if (w_div) begin
            s_hi = ddiff[W] ? dshift[W-1:0] : ddiff[W-1:0];
            s_lo = {w_lo[W-2:0], ~ddiff[W]};
        end else begin
            s_hi = msum[W:1];
            s_lo = {msum[0], w_lo[W-1:1]};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = fast ? DONE : RUN;
            RUN:     if (last_iter) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            sel_q  <= '0;
            Result <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                div_q  <= op_div;
                sel_q  <= Operation[1:0];
                negq_q <= a_neg ^ b_neg;
                negr_q <= a_neg;
                b_q    <= w_b;
                hi_q   <= s_hi;
                lo_q   <= s_lo;
                cnt_q  <= '0;
                if (fast) Result <= fast_res;
            end else if (state == RUN) begin
                hi_q  <= s_hi;
                lo_q  <= s_lo;
                cnt_q <= cnt_q + 1'b1;
                if (last_iter) Result <= fixup(div_q, sel_q, negq_q, negr_q, s_hi, s_lo);
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases plus randomized ops vs an arithmetic model.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Operation = '0;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic        Busy, Done;
    logic [31:0] Result;

    muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Operation(Operation),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        logic [2:0]  op;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        logic        of;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        of = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (of) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (of) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 32;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Caller sits at a negedge with the DUT idle; returns one negedge later.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] exp_res);
        exp_t e;
        Start = 1'b1; Operation = op; SrcA = a; SrcB = b;
        if (push) begin
            e.res = exp_res; e.acc = cyc + 1; e.lat = ref_lat(op, a, b); e.op = op;
            q.push_back(e);
        end
        @(negedge clk);
        Start = 1'b0;
        SrcA = $urandom; SrcB = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int busy_cycles;
        fork
            forever @(posedge clk) cyc++;
            forever begin
                @(negedge clk);
                if (!reset && Done) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check($sformatf("result_op%0d", e.op), Result, e.res);
                        check($sformatf("latency_op%0d", e.op), 32'(cyc - e.acc + 1), 32'(e.lat));
                        if (!Busy) check("busy_at_done", 32'(Busy), 32'd1);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_result", Result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB);
        busy_cycles = 0;
        for (int i = 0; i < 100 && Busy; i++) begin
            busy_cycles++;
            @(negedge clk);
        end
`ifdef MULDIV_FAST_MUL_EN
        check("mul_busy_cycles", 32'(busy_cycles), 32'd1);
`else
        check("mul_busy_cycles", 32'(busy_cycles), 32'd32);
`endif
        drain();

        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000); drain();
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE); drain();
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF); drain();
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD); drain();
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF); drain();
        issue(3'd5, 32'd100, 32'd7, 1'b1, 32'd14); drain();
        issue(3'd7, 32'd100, 32'd7, 1'b1, 32'd2); drain();
        issue(3'd4, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF); drain();
        issue(3'd7, 32'd5, 32'd0, 1'b1, 32'd5); drain();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000); drain();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0); drain();
        issue(3'd0, 32'd6, 32'd7, 1'b1, 32'd42); drain();
        issue(3'd5, 32'd42, 32'd6, 1'b1, 32'd7); drain();

        // Start while busy must be ignored without re-sampling operands.
        issue(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
        repeat (4) @(negedge clk);
        Start = 1'b1; Operation = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
        @(negedge clk);
        Start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("result_held", Result, 32'd14);

        // Reset mid-run aborts with no Done.
        issue(3'd5, 32'd100, 32'd7, 1'b0, 32'd0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_result", Result, 32'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = rnd_opnd();
            b  = rnd_opnd();
            issue(op, a, b, 1'b1, ref_res(op, a, b));
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
